// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier: controller state
// encoding and the enable bundle the controller hands to the datapath.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic load;   // capture operand magnitudes, clear accumulator and counter
    logic shift;  // one shift-add iteration
    logic count;  // advance the iteration counter
    logic done;   // final iteration: register the signed product
  } ctrl_en_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_multiplier: sequences IDLE -> CALC -> DONE and emits
// datapath enables plus registered handshake outputs.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     src_valid,
  input  logic     dst_ready,
  input  logic     last_iter,
  output logic     src_ready,
  output logic     dst_valid,
  output ctrl_en_t en
);

  state_e state_q;
  logic   src_ready_q;
  logic   dst_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_ready_q <= 1'b1;
      dst_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (src_valid) begin
            state_q     <= CALC;
            src_ready_q <= 1'b0;
          end
        end
        CALC: begin
          if (last_iter) begin
            state_q     <= DONE;
            dst_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (dst_ready) begin
            state_q     <= IDLE;
            dst_valid_q <= 1'b0;
            src_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          src_ready_q <= 1'b1;
          dst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // src_ready is high exactly in IDLE, so the accept condition needs only src_valid.
  always_comb begin
    en       = '0;
    en.load  = (state_q == IDLE) && src_valid;
    en.shift = (state_q == CALC);
    en.count = (state_q == CALC);
    en.done  = (state_q == CALC) && last_iter;
  end

  assign src_ready = src_ready_q;
  assign dst_valid = dst_valid_q;

endmodule : seq_mult_ctrl

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: signed/unsigned WIDTH x WIDTH -> 2*WIDTH,
// one iteration per cycle on operand magnitudes, sign applied at the end.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] product,
  output logic               dst_valid,
  input  logic               dst_ready
);

  localparam int PW = 2 * WIDTH;

  ctrl_en_t en;
  logic     last_iter;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;

  seq_mult_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .dst_ready (dst_ready),
    .last_iter (last_iter),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .en        (en)
  );

  // Two's-complement of -2^(WIDTH-1) wraps to itself, which read as unsigned
  // is exactly the required magnitude 2^(WIDTH-1).
  assign a_neg = is_signed & multiplicand[WIDTH-1];
  assign b_neg = is_signed & multiplier[WIDTH-1];
  assign a_mag = a_neg ? (~multiplicand) + WIDTH'(1) : multiplicand;
  assign b_mag = b_neg ? (~multiplier) + WIDTH'(1) : multiplier;

  assign partial   = mplier_q[0] ? mcand_q : '0;
  assign acc_sum   = acc_q + partial;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (en.load) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      neg_d    = a_neg ^ b_neg;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (en.shift) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end

    if (en.count) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The last iteration's sum is folded straight into the result register.
    if (en.done) begin
      product_d = neg_q ? (~acc_sum) + PW'(1) : acc_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=16): directed corner cases plus
// random operations compared against a plain-arithmetic reference product.
module tb_seq_multiplier;

  localparam int WIDTH = 16;
  localparam int PW    = 2 * WIDTH;

  logic            clk;
  logic            reset;
  logic            src_valid;
  logic            src_ready;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic            is_signed;
  logic [PW-1:0]   product;
  logic            dst_valid;
  logic            dst_ready;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .is_signed    (is_signed),
    .product      (product),
    .dst_valid    (dst_valid),
    .dst_ready    (dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mult(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return PW'(x * y);
  endfunction

  // One full transaction. hold = cycles dst_ready stays low in DONE
  // (0 means dst_ready is already high from the accept onward).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input int hold);
    logic [PW-1:0] exp_p;
    int edges;
    exp_p = ref_mult(a, b, s);
    @(negedge clk);
    check("src_ready_idle", src_ready, 1'b1);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    src_valid    = 1'b1;
    dst_ready    = (hold == 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    while (!dst_valid && edges < 60) begin
      // Busy: operand and valid noise must not leak into the result.
      src_valid    = 1'($urandom);
      multiplicand = WIDTH'($urandom);
      multiplier   = WIDTH'($urandom);
      is_signed    = 1'($urandom);
      if (edges == 2) check("src_ready_calc", src_ready, 1'b0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency_edges", 64'(edges), 64'(WIDTH + 1));
    check("product", product, exp_p);
    check("src_ready_done", src_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      src_valid    = 1'($urandom);
      multiplicand = WIDTH'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", dst_valid, 1'b1);
      check("hold_product", product, exp_p);
    end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", dst_valid, 1'b0);
    check("idle_ready", src_ready, 1'b1);
    check("product_kept", product, exp_p);
    dst_ready = 1'($urandom);
    $display("op a=0x%04h b=0x%04h signed=%0d hold=%0d product=0x%08h expected=0x%08h latency=%0d",
             a, b, s, hold, product, exp_p, edges);
  endtask

  initial begin
    logic seen_valid;
    reset        = 1'b0;
    src_valid    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    is_signed    = 1'b0;
    dst_ready    = 1'b0;
    #1;
    check("reset_product", product, '0);
    check("reset_dst_valid", dst_valid, 1'b0);
    #20;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", src_ready, 1'b1);

    run_op(16'd3,    16'd5,    1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 1);
    run_op(16'hFFFD, 16'h0005, 1'b1, 2);
    run_op(16'h0000, 16'hBEEF, 1'b1, 0);
    run_op(16'h1234, 16'h0000, 1'b0, 0);
    run_op(16'h7FFF, 16'h8000, 1'b1, 5);

    // Abort mid-calculation: reset at iteration counter 7.
    run_op(16'd3, 16'd5, 1'b0, 0);
    @(negedge clk);
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    is_signed    = 1'b0;
    src_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_product", product, '0);
    check("abort_valid", dst_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dst_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", seen_valid, 1'b0);
    check("abort_ready", src_ready, 1'b1);
    run_op(16'd2, 16'd2, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_multiplier
